bus_master_arbiter: RTL and testbench
=====================================

Name: bus_master_arbiter

Overview:
- Round-robin arbiter sharing the single system bus between up to NUM_MASTERS bus masters, e.g. the JTAG support bridge and a CPU/DMA.
- Each master raises its request bit and drives the bus only while its granted bit is high.
- Monitors the shared begin/end/error transaction signals to know when the bus is free.
- Reclaims grants from masters that never start a transaction.

Parameters:
- NUM_MASTERS, 4, number of requesters; legal range 2..16.
- TIMEOUT_CYCLES, 256, cycles a master may hold a grant without asserting begin_transactionIN; legal range >= 2.

Ports:
- system_clock  input  1  single clock; all logic on rising edge.
- system_reset  input  1  synchronous, active-high reset.
- request  input  NUM_MASTERS  per-master bus request, level-sensitive.
- granted  output  NUM_MASTERS  one-hot (or zero) grant, registered.
- grant_index  output  $clog2(NUM_MASTERS)  index of current/last granted master.
- begin_transactionIN  input  1  shared bus begin strobe (1 cycle).
- end_transactionIN  input  1  shared bus end strobe (1 cycle).
- errorIN  input  1  shared bus error; terminates transaction.
- bus_active  output  1  high in GRANTED or ACTIVE.
- timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset values (next edge with system_reset=1, overrides any state, including mid-transaction):
  - state=IDLE, granted=0, grant_index=NUM_MASTERS-1, timeout counter=0, timeout_pulse=0, bus_active=0.
- FSM states: IDLE, GRANTED, ACTIVE, HANDOVER.
- IDLE:
  - If request!=0, select the first set bit scanning from grant_index+1 upward, wrapping modulo NUM_MASTERS.
  - Next edge: state=GRANTED, granted=one-hot of winner, grant_index=winner, counter=0.
  - Latency from request sampled in IDLE to granted high: 1 cycle.
  - If request==0, remain in IDLE with granted=0.
- GRANTED (priority order, highest first):
  1. begin_transactionIN and (end_transactionIN or errorIN) in the same cycle -> HANDOVER (zero-length transaction).
  2. begin_transactionIN -> ACTIVE.
  3. request[grant_index]==0 -> HANDOVER (master withdrew).
  4. counter==TIMEOUT_CYCLES-1 -> HANDOVER, timeout_pulse=1 for exactly that next cycle.
  5. Otherwise counter+1.
- ACTIVE:
  - end_transactionIN or errorIN -> HANDOVER.
  - request changes are ignored; the grant is held until the transaction ends.
  - No timeout in ACTIVE.
- HANDOVER:
  - granted=0 for exactly one cycle (bus turnaround), then IDLE unconditionally.
  - Minimum gap between consecutive grants: 2 cycles with granted=0 (HANDOVER + IDLE).
- Outputs:
  - granted is nonzero only in GRANTED/ACTIVE and never has more than one bit set.
  - grant_index holds its value after release; it is the round-robin pointer.
- Fairness: a continuously requesting master waits at most NUM_MASTERS-1 other grants.
- Width rules:
  - Counter width = $clog2(TIMEOUT_CYCLES); no overflow, because the counter is bounded by the compare.
  - Pointer wrap is done with an explicit compare, not power-of-two truncation, so non-power-of-two NUM_MASTERS works.
- Strobes outside GRANTED/ACTIVE (begin/end/error in IDLE or HANDOVER) are ignored.

Test Plan:
1. Reset, then request=4'b0001 -> granted=4'b0001 one cycle later, grant_index=0. Then begin, 3 cycles, end -> one cycle granted=0 (HANDOVER), then IDLE.
2. request=4'b1111 held; each grant completed with begin/end -> grant order 0,1,2,3,0. granted is always one-hot or zero; 2 zero-grant cycles between grants.
3. request=4'b0100, never begin, TIMEOUT_CYCLES=8 -> granted=4'b0100 for exactly 8 cycles. Then timeout_pulse=1 for 1 cycle, granted=0, and master 2 is regranted after IDLE.
4. Granted master 1 in ACTIVE, request drops to 0 -> grant held. errorIN pulse -> HANDOVER next edge, granted=0.
5. begin_transactionIN and end_transactionIN in the same cycle during GRANTED -> direct to HANDOVER, no ACTIVE cycle, no timeout_pulse.
6. system_reset asserted during ACTIVE with granted=4'b0010 -> next edge granted=0, IDLE, grant_index=3. Then request=4'b0011 -> master 0 granted first.

Source files
------------

// File: rtl/bus_master_arbiter_if.sv
// Shared-bus arbitration signals between requesting masters and the arbiter.
// slave: arbiter side (drives grants); master: requester side (drives requests and bus strobes).
interface bus_master_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] request;
    logic [NUM_MASTERS-1:0] granted;
    logic [IW-1:0]          grant_index;
    logic                   begin_transactionIN;
    logic                   end_transactionIN;
    logic                   errorIN;
    logic                   bus_active;
    logic                   timeout_pulse;

    modport slave (
        input  request, begin_transactionIN, end_transactionIN, errorIN,
        output granted, grant_index, bus_active, timeout_pulse
    );

    modport master (
        output request, begin_transactionIN, end_transactionIN, errorIN,
        input  granted, grant_index, bus_active, timeout_pulse
    );
endinterface

// File: rtl/bus_master_arbiter.sv
// Round-robin owner of the shared system bus; grant registered 1 cycle after request seen in IDLE.
// No backpressure: bus strobes outside GRANTED/ACTIVE are dropped; idle grants are revoked after TIMEOUT_CYCLES.
module bus_master_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 system_clock,
    input  logic                 system_reset,
    bus_master_arbiter_if.slave  bus
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, GRANTED, ACTIVE, HANDOVER} state_t;

    state_t                 state_q,         state_d;
    logic [NUM_MASTERS-1:0] granted_q,       granted_d;
    logic [IW-1:0]          grant_index_q,   grant_index_d;
    logic [CW-1:0]          cnt_q,           cnt_d;
    logic                   bus_active_q,    bus_active_d;
    logic                   timeout_pulse_q, timeout_pulse_d;

    logic [IW-1:0] cand;
    logic [IW-1:0] winner;
    logic          found;
    logic          txn_done;

    // Scan from the slot after the last winner; the wrap is an explicit compare so odd master counts work.
    always_comb begin
        cand   = grant_index_q;
        winner = grant_index_q;
        found  = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (cand == IW'(NUM_MASTERS - 1)) cand = '0;
            else                              cand = cand + IW'(1);
            if (!found && bus.request[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign txn_done = bus.end_transactionIN | bus.errorIN;

    always_comb begin
        state_d         = state_q;
        granted_d       = granted_q;
        grant_index_d   = grant_index_q;
        cnt_d           = cnt_q;
        timeout_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                granted_d = '0;
                if (found) begin
                    state_d       = GRANTED;
                    granted_d     = NUM_MASTERS'(1) << winner;
                    grant_index_d = winner;
                    cnt_d         = '0;
                end
            end
            GRANTED: begin
                if (bus.begin_transactionIN && txn_done) begin
                    state_d   = HANDOVER;
                    granted_d = '0;
                end else if (bus.begin_transactionIN) begin
                    state_d = ACTIVE;
                end else if (!bus.request[grant_index_q]) begin
                    state_d   = HANDOVER;
                    granted_d = '0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d         = HANDOVER;
                    granted_d       = '0;
                    timeout_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACTIVE: begin
                if (txn_done) begin
                    state_d   = HANDOVER;
                    granted_d = '0;
                end
            end
            HANDOVER: begin
                state_d   = IDLE;
                granted_d = '0;
            end
            default: begin
                state_d   = IDLE;
                granted_d = '0;
            end
        endcase
        bus_active_d = (state_d == GRANTED) || (state_d == ACTIVE);
    end

    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            state_q         <= IDLE;
            granted_q       <= '0;
            grant_index_q   <= IW'(NUM_MASTERS - 1);
            cnt_q           <= '0;
            bus_active_q    <= 1'b0;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            granted_q       <= granted_d;
            grant_index_q   <= grant_index_d;
            cnt_q           <= cnt_d;
            bus_active_q    <= bus_active_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign bus.granted       = granted_q;
    assign bus.grant_index   = grant_index_q;
    assign bus.bus_active    = bus_active_q;
    assign bus.timeout_pulse = timeout_pulse_q;
endmodule

// File: tb/tb_bus_master_arbiter.sv
// Transaction-level bench: driver predicts each grant (owner, length, timeout) into a queue;
// a negedge monitor reconstructs grants from the outputs and pops the queue to compare.
module tb_bus_master_arbiter;
    localparam int N   = 4;
    localparam int TMO = 8;

    localparam int K_END  = 0;
    localparam int K_ERR  = 1;
    localparam int K_ZERO = 2;
    localparam int K_WD   = 3;
    localparam int K_TMO  = 4;
    localparam int K_RST  = 5;

    typedef struct {
        int master;
        int len;
        bit tmo;
    } exp_t;

    logic clk;
    logic rst;
    logic rst_q;
    bit   done;
    bit   mon_en;
    exp_t exp_q[$];
    int   ptr;

    int   checks;
    int   errors;
    logic [N-1:0] prev_g;
    logic [N-1:0] g;
    int   gap;
    int   len;
    int   cur_idx;
    exp_t e_mon;

    bus_master_arbiter_if #(.NUM_MASTERS(N)) bif ();

    bus_master_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TMO)) dut (
        .system_clock (clk),
        .system_reset (rst),
        .bus          (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rst_q <= rst;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic int rr_pick(input int p, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (p + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive random bus strobes for one cycle while the bus is known to be unowned.
    task automatic strobe_step();
        bif.begin_transactionIN = 1'($urandom_range(0, 1));
        bif.end_transactionIN   = 1'($urandom_range(0, 1));
        bif.errorIN             = 1'($urandom_range(0, 1));
        step();
        bif.begin_transactionIN = 1'b0;
        bif.end_transactionIN   = 1'b0;
        bif.errorIN             = 1'b0;
    endtask

    task automatic do_txn(input logic [N-1:0] req, input int kind, input int d, input int n, input int idle);
        exp_t e;
        int   w;
        int   t;
        if (idle > 0) begin
            bif.request = '0;
            repeat (idle) strobe_step();
        end
        bif.request = req;
        w = rr_pick(ptr, req);
        e.master = w;
        e.tmo    = 1'b0;
        case (kind)
            K_ZERO, K_WD: e.len = d + 1;
            K_TMO: begin
                e.len = TMO;
                e.tmo = 1'b1;
            end
            default: e.len = d + 2 + n;
        endcase
        exp_q.push_back(e);
        ptr = w;

        t = 0;
        while (bif.granted == '0) begin
            if (t == 10) begin
                $display("FAIL grant_wait: no grant after %0d cycles, expected master %0d", t, w);
                $fatal(1, "grant wait expired");
            end
            strobe_step();
            t++;
        end

        case (kind)
            K_TMO: repeat (TMO) step();
            K_WD: begin
                repeat (d) step();
                bif.request[w] = 1'b0;
                step();
            end
            K_ZERO: begin
                repeat (d) step();
                bif.begin_transactionIN = 1'b1;
                if ($urandom_range(0, 1) == 1) bif.end_transactionIN = 1'b1;
                else                           bif.errorIN           = 1'b1;
                step();
                bif.begin_transactionIN = 1'b0;
                bif.end_transactionIN   = 1'b0;
                bif.errorIN             = 1'b0;
            end
            default: begin
                repeat (d) step();
                bif.begin_transactionIN = 1'b1;
                step();
                bif.begin_transactionIN = 1'b0;
                repeat (n) begin
                    bif.request = N'($urandom_range(0, (1 << N) - 1));
                    step();
                end
                if (kind == K_RST) begin
                    rst = 1'b1;
                    step();
                    step();
                    rst = 1'b0;
                    ptr = N - 1;
                end else begin
                    if (kind == K_ERR) bif.errorIN = 1'b1;
                    else               bif.end_transactionIN = 1'b1;
                    step();
                    bif.end_transactionIN = 1'b0;
                    bif.errorIN           = 1'b0;
                end
            end
        endcase
    endtask

    initial begin
        rst                     = 1'b1;
        done                    = 1'b0;
        bif.request             = '0;
        bif.begin_transactionIN = 1'b0;
        bif.end_transactionIN   = 1'b0;
        bif.errorIN             = 1'b0;
        ptr                     = N - 1;
        repeat (3) step();
        rst = 1'b0;

        do_txn(4'b0001, K_END, 0, 3, 0);
        repeat (5) do_txn(4'b1111, K_END, 1, 1, 0);
        do_txn(4'b0100, K_TMO, 0, 0, 0);
        do_txn(4'b0100, K_END, 2, 0, 0);
        do_txn(4'b0010, K_ERR, 0, 3, 0);
        do_txn(4'b1000, K_ZERO, 3, 0, 0);
        do_txn(4'b0001, K_WD, 2, 0, 0);
        do_txn(4'b0110, K_ZERO, 0, 0, 2);

        for (int i = 0; i < 150; i++) begin
            do_txn(N'($urandom_range(1, (1 << N) - 1)),
                   int'($urandom_range(0, 4)),
                   int'($urandom_range(0, TMO - 1)),
                   int'($urandom_range(0, 5)),
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        do_txn(4'b0010, K_RST, 0, 2, 0);
        do_txn(4'b0011, K_END, 0, 0, 0);

        repeat (3) step();
        done = 1'b1;
    end

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        prev_g = '0;
        gap    = 100;
        len    = 0;
        cur_idx = -1;
    end

    always @(negedge clk) begin
        if (rst_q === 1'b1) begin
            if (!mon_en) begin
                mon_en = 1'b1;
                prev_g = '0;
                gap    = 100;
            end
            chk(bif.granted == '0,         "reset_granted",     int'(bif.granted),       0);
            chk(bif.grant_index == N - 1,  "reset_grant_index", int'(bif.grant_index),   N - 1);
            chk(bif.bus_active == 1'b0,    "reset_bus_active",  int'(bif.bus_active),    0);
            chk(bif.timeout_pulse == 1'b0, "reset_timeout",     int'(bif.timeout_pulse), 0);
        end
        if (mon_en) begin
            g = bif.granted;
            chk($onehot0(g), "onehot_grant", int'(g), 0);
            chk(bif.bus_active == (g != '0), "bus_active", int'(bif.bus_active), int'(g != '0));
            if (g != '0 && prev_g == '0) begin
                cur_idx = -1;
                for (int i = 0; i < N; i++) if (g[i]) cur_idx = i;
                len = 1;
                chk(int'(bif.grant_index) == cur_idx, "grant_index", int'(bif.grant_index), cur_idx);
                chk(gap >= 2, "grant_gap", gap, 2);
                chk(bif.timeout_pulse == 1'b0, "pulse_in_grant", int'(bif.timeout_pulse), 0);
            end else if (g != '0) begin
                len++;
                chk(g == prev_g, "grant_stable", int'(g), int'(prev_g));
                chk(bif.timeout_pulse == 1'b0, "pulse_in_grant", int'(bif.timeout_pulse), 0);
            end else if (prev_g != '0) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_grant", cur_idx, -1);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk(cur_idx == e_mon.master, "grant_master", cur_idx, e_mon.master);
                    chk(len == e_mon.len, "grant_len", len, e_mon.len);
                    chk(bif.timeout_pulse == e_mon.tmo, "timeout_pulse", int'(bif.timeout_pulse), int'(e_mon.tmo));
                end
                gap = 1;
            end else begin
                gap++;
                chk(bif.timeout_pulse == 1'b0, "stray_timeout", int'(bif.timeout_pulse), 0);
            end
            prev_g = g;
            if (done) begin
                chk(exp_q.size() == 0, "pending_grants", exp_q.size(), 0);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end
endmodule
